// File: rtl/drvr_fifo_bus_if.sv
// Circular-buffer FIFO between a driver and the bus arbiter. The head word falls through to D_pop, so a push shows on pndng/D_pop one edge later.
// A push while full is dropped unless a pop happens in the same cycle. Dropped pushes and empty pops set the sticky ovf/udf flags.
module drvr_fifo_bus_if #(
  parameter int bits  = 32,
  parameter int depth = 8,
  parameter int cw    = $clog2(depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  input  logic            pop,
  output logic [bits-1:0] D_pop,
  output logic            pndng,
  output logic            full,
  output logic [cw-1:0]   count,
  output logic            ovf,
  output logic            udf
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;

  logic [bits-1:0] mem [depth];
  logic [aw-1:0]   wp;
  logic [aw-1:0]   rp;
  logic            push_ok;
  logic            pop_ok;

  assign pndng = (count != '0);
  assign full  = (count == cw'(depth));
  assign D_pop = pndng ? mem[rp] : '0;

  // When the FIFO is full, a simultaneous pop frees a slot, so the push can be accepted.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && pndng;

  // Storage is not reset. The pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= D_push;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + aw'(1);
      end
      if (pop_ok) begin
        rp <= rp + aw'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + cw'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - cw'(1);
      end
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end
      if (pop && !pndng && !push) begin
        udf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_drvr_fifo_bus_if.sv
// Directed bench for drvr_fifo_bus_if. A queue scoreboard holds the words expected on D_pop.
module tb_drvr_fifo_bus_if;

  localparam int BITS  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk    = 1'b0;
  logic            reset  = 1'b0;
  logic            push   = 1'b0;
  logic            pop    = 1'b0;
  logic [BITS-1:0] D_push = '0;
  logic [BITS-1:0] D_pop;
  logic            pndng;
  logic            full;
  logic [CW-1:0]   count;
  logic            ovf;
  logic            udf;

  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] sb[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  drvr_fifo_bus_if #(.bits(BITS), .depth(DEPTH), .cw(CW)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " count"}, BITS'(count), BITS'(sb.size()));
    chk({tag, " pndng"}, BITS'(pndng), BITS'(sb.size() != 0));
    chk({tag, " full"},  BITS'(full),  BITS'(sb.size() == DEPTH));
    chk({tag, " ovf"},   BITS'(ovf),   BITS'(m_ovf));
    chk({tag, " udf"},   BITS'(udf),   BITS'(m_udf));
    chk({tag, " D_pop"}, D_pop, (sb.size() != 0) ? sb[0] : '0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " count"}, BITS'(count), '0);
    chk({tag, " pndng"}, BITS'(pndng), '0);
    chk({tag, " full"},  BITS'(full),  '0);
    chk({tag, " ovf"},   BITS'(ovf),   '0);
    chk({tag, " udf"},   BITS'(udf),   '0);
    chk({tag, " D_pop"}, D_pop, '0);
  endtask

  // Runs one clock cycle. Inputs are driven after the falling edge. The scoreboard is updated, and the DUT state is compared 1 time unit after the rising edge.
  task automatic cycle(input logic p, input logic [BITS-1:0] d, input logic q);
    logic was_full;
    logic was_empty;
    @(negedge clk);
    push = p; D_push = d; pop = q;
    #1;
    was_full  = (sb.size() == DEPTH);
    was_empty = (sb.size() == 0);
    if (q && !was_empty) begin
      chk("pop data", D_pop, sb[0]);
      void'(sb.pop_front());
    end
    if (p && (!was_full || q)) sb.push_back(d);
    if (p && was_full && !q) m_ovf = 1'b1;
    if (q && was_empty && !p) m_udf = 1'b1;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    chk_model("post");
  endtask

  // Asserts reset in the middle of a cycle. The outputs must clear at once, and push/pop must be ignored while reset is held.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0; push = 1'b1; pop = 1'b1; D_push = 32'hBAD0BAD0;
    #1;
    chk_zero("async reset");
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("held reset");
    @(negedge clk);
    push = 1'b0; pop = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    chk_model("after release");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_zero("idle");

    // Fill to full, then drain in order.
    for (int i = 1; i <= 8; i++) cycle(1'b1, BITS'(i), 1'b0);
    chk("fill full", BITS'(full), 1);
    chk("fill count", BITS'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain seq", D_pop, BITS'(i));
      cycle(1'b0, '0, 1'b1);
    end
    chk("drained pndng", BITS'(pndng), 0);

    // Overflow: the extra word is dropped.
    for (int i = 1; i <= 8; i++) cycle(1'b1, BITS'(i), 1'b0);
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    chk("ovf set", BITS'(ovf), 1);
    chk("ovf count", BITS'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf drain", D_pop, BITS'(i));
      cycle(1'b0, '0, 1'b1);
    end
    chk("ovf sticky", BITS'(ovf), 1);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 32'h100 + BITS'(i), 1'b0);
    cycle(1'b1, 32'hA5A5A5A5, 1'b1);
    chk("fullpp count", BITS'(count), 8);
    chk("fullpp ovf", BITS'(ovf), 0);
    for (int i = 1; i <= 8; i++) begin
      chk("fullpp drain", D_pop, (i == 8) ? 32'hA5A5A5A5 : 32'h100 + BITS'(i + 1));
      cycle(1'b0, '0, 1'b1);
    end

    // Underflow, then push and pop together while empty.
    cycle(1'b0, '0, 1'b1);
    chk("udf set", BITS'(udf), 1);
    chk("udf count", BITS'(count), 0);
    cycle(1'b1, 32'h12345678, 1'b1);
    chk("emptypp count", BITS'(count), 1);
    chk("emptypp data", D_pop, 32'h12345678);
    chk("emptypp udf", BITS'(udf), 1);
    cycle(1'b0, '0, 1'b1);

    // Interleaved stream with pointer wrap and a reset in mid-stream.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC000 + BITS'(i), 1'b0);
    for (int i = 3; i < 8; i++) cycle(1'b1, 32'hC000 + BITS'(i), 1'b1);
    chk("pre-reset head", D_pop, 32'hC005);
    do_reset();
    cycle(1'b1, 32'hBEEF0001, 1'b0);
    chk("post-reset head", D_pop, 32'hBEEF0001);
    for (int i = 2; i <= 4; i++) cycle(1'b1, 32'hBEEF0000 + BITS'(i), 1'b1);
    chk("stream head", D_pop, 32'hBEEF0004);
    cycle(1'b0, '0, 1'b1);
    chk("stream empty", BITS'(pndng), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
